// File: rtl/pl_stage_pkg.sv
// ---------------------------------------------------------------------------
// pl_stage_pkg
// Purpose : shared types and constants for the generic pipeline stage
//           register (pl_stage_reg) and its optional skid buffer.
//           Holds the per-stage control/data packed structs that the
//           instantiating stages cast to CTRL_W / DATA_W, the per-stage
//           bubble-safe control constants, default widths and a small
//           helper used by the occupancy-based flush counter.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pl_stage_pkg;

    // Default widths of the generic stage register
    localparam int PL_CTRL_W = 16;
    localparam int PL_DATA_W = 160;
    localparam int PL_CNT_W  = 16;

    // Identifies which pipeline boundary an instance sits on
    typedef enum logic [1:0] {
        STG_IFID  = 2'd0,
        STG_IDEX  = 2'd1,
        STG_EXMEM = 2'd2,
        STG_MEMWB = 2'd3
    } pl_stage_e;

    // IF/ID: no control yet, only the fetched instruction and PC+4
    typedef struct packed {
        logic [15:0] rsvd;
    } ifid_ctrl_t;

    typedef struct packed {
        logic [95:0] pad;
        logic [31:0] instr;
        logic [31:0] pcn;
    } ifid_data_t;

    // ID/EX: full decoded control set
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [6:0] rsvd;
    } idex_ctrl_t;

    typedef struct packed {
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [31:0] pcn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [16:0] pad;
    } idex_data_t;

    // EX/MEM: memory and write-back control remain
    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic [10:0] rsvd;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] wdat;
        logic [31:0] br_tgt;
        logic        zero;
        logic [4:0]  wreg;
        logic [57:0] pad;
    } exmem_data_t;

    // MEM/WB: write-back control only
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [13:0] rsvd;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] alu_res;
        logic [4:0]  wreg;
        logic [90:0] pad;
    } memwb_data_t;

    // Bubble-safe control values: every write/read enable deasserted
    localparam ifid_ctrl_t  IFID_CTRL_RST  = '{rsvd: 16'h0000};
    localparam idex_ctrl_t  IDEX_CTRL_RST  = '{mem_read: 1'b0, mem_write: 1'b0,
                                               reg_write: 1'b0, mem_to_reg: 1'b0,
                                               branch: 1'b0, alu_src: 1'b0,
                                               reg_dst: 1'b0, alu_op: 2'b00,
                                               rsvd: 7'h00};
    localparam exmem_ctrl_t EXMEM_CTRL_RST = '{mem_read: 1'b0, mem_write: 1'b0,
                                               reg_write: 1'b0, mem_to_reg: 1'b0,
                                               branch: 1'b0, rsvd: 11'h000};
    localparam memwb_ctrl_t MEMWB_CTRL_RST = '{reg_write: 1'b0, mem_to_reg: 1'b0,
                                               rsvd: 14'h0000};

    // Number of live beats held by the stage (main register + skid entry)
    function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
        occupancy = {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pl_skid_buf.sv
// ---------------------------------------------------------------------------
// pl_skid_buf
// Purpose : one-entry skid register that sits behind the main stage register
//           of pl_stage_reg. It absorbs a beat accepted while the main
//           register is full and not draining, and hands it to the main
//           register on the next drain. Only built when PL_STAGE_SKID_EN is
//           defined; with the macro undefined this file is empty.
// Ports   : i_clk, i_rst      clock / synchronous active-high reset
//           i_flush           squash the skid entry
//           i_accept          upstream beat taken this cycle
//           i_drain           downstream takes the main register this cycle
//           i_main_valid      main register currently holds a beat
//           i_ctrl, i_data    upstream payload
//           o_skid_valid      skid entry occupied
//           o_skid_ctrl/data  skid payload (ctrl is CTRL_RST when empty)
//           o_move            main register loads from the skid this edge
//           o_load_main       main register loads from the input this edge
// ---------------------------------------------------------------------------
`ifdef PL_STAGE_SKID_EN
module pl_skid_buf
    import pl_stage_pkg::*;
#(
    parameter int                CTRL_W   = PL_CTRL_W,
    parameter int                DATA_W   = PL_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_accept,
    input  logic              i_drain,
    input  logic              i_main_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_skid_valid,
    output logic [CTRL_W-1:0] o_skid_ctrl,
    output logic [DATA_W-1:0] o_skid_data,
    output logic              o_move,
    output logic              o_load_main
);

    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_valid_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    // The older skid beat always goes first; a fresh beat reaches the main
    // register directly only when the skid is empty and main is free or leaving.
    assign o_move      = i_drain && r_skid_valid;
    assign o_load_main = i_accept && !r_skid_valid && (!i_main_valid || i_drain);

    // Skid next-state: capture, hand-over to main, or clear on flush
    always_comb begin
        w_valid_nxt = r_skid_valid;
        w_ctrl_nxt  = r_skid_ctrl;
        w_data_nxt  = r_skid_data;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = CTRL_RST;
        end else if (r_skid_valid) begin
            if (i_drain) begin
                // Skid content moves to main; a simultaneous accept refills it
                if (i_accept) begin
                    w_valid_nxt = 1'b1;
                    w_ctrl_nxt  = i_ctrl;
                    w_data_nxt  = i_data;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_ctrl_nxt  = CTRL_RST;
                end
            end else begin
                w_valid_nxt = r_skid_valid;
            end
        end else begin
            if (i_accept && i_main_valid && !i_drain) begin
                w_valid_nxt = 1'b1;
                w_ctrl_nxt  = i_ctrl;
                w_data_nxt  = i_data;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    // Skid register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= CTRL_RST;
            r_skid_data  <= {DATA_W{1'b0}};
        end else begin
            r_skid_valid <= w_valid_nxt;
            r_skid_ctrl  <= w_ctrl_nxt;
            r_skid_data  <= w_data_nxt;
        end
    end

    assign o_skid_valid = r_skid_valid;
    assign o_skid_ctrl  = r_skid_ctrl;
    assign o_skid_data  = r_skid_data;

endmodule
`endif

// File: rtl/pl_stage_reg.sv
// ---------------------------------------------------------------------------
// pl_stage_reg
// Purpose : generic pipeline stage register with valid/ready handshake,
//           hazard hold, flush, a guaranteed-safe bubble (control forced to
//           CTRL_RST whenever the stage is empty) and saturating stall/flush
//           performance counters.
// Config  : PL_STAGE_SKID_EN - when defined, a one-entry skid (pl_skid_buf)
//           sits behind the main register and in_ready no longer depends
//           combinationally on out_ready. Undefined: single register with
//           comb in_ready.
// Ports   : CLK, RST              clock / synchronous active-high reset
//           in_valid, in_ready    upstream handshake
//           in_ctrl, in_data      upstream payload (ctrl / data split)
//           hold                  hazard stall: refuse input
//           flush                 squash stage contents and offered beat
//           out_valid, out_ready  downstream handshake
//           out_ctrl, out_data    registered payload
//           out_bubble            !out_valid
//           stall_cnt, flush_cnt  saturating perf counters
// ---------------------------------------------------------------------------
module pl_stage_reg
    import pl_stage_pkg::*;
#(
    parameter int                CTRL_W   = PL_CTRL_W,
    parameter int                DATA_W   = PL_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
    parameter int                CNT_W    = PL_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Adds a small increment, clamping at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_move;
    logic              w_load_in;

    logic              w_valid_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]  w_stall_nxt;
    logic [CNT_W-1:0]  w_flush_nxt;

    assign w_accept = in_valid && w_in_ready;
    assign w_drain  = r_valid && out_ready;

`ifdef PL_STAGE_SKID_EN
    // Ready depends only on local state; the skid catches the one beat that
    // may arrive while the downstream is not taking the main register.
    assign w_in_ready = !hold && !flush && !w_skid_valid;

    pl_skid_buf #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_flush      (flush),
        .i_accept     (w_accept),
        .i_drain      (w_drain),
        .i_main_valid (r_valid),
        .i_ctrl       (in_ctrl),
        .i_data       (in_data),
        .o_skid_valid (w_skid_valid),
        .o_skid_ctrl  (w_skid_ctrl),
        .o_skid_data  (w_skid_data),
        .o_move       (w_move),
        .o_load_main  (w_load_in)
    );
`else
    // Accept when empty or when the current beat leaves this same cycle
    assign w_in_ready   = !hold && !flush && (!r_valid || out_ready);
    assign w_skid_valid = 1'b0;
    assign w_skid_ctrl  = CTRL_RST;
    assign w_skid_data  = {DATA_W{1'b0}};
    assign w_move       = 1'b0;
    assign w_load_in    = w_accept;
`endif

    // Main register next-state; flush beats everything but reset, and hold
    // only acts through in_ready so a drain under hold still empties the stage
    always_comb begin
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        w_data_nxt  = r_data;
        if (flush) begin
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = CTRL_RST;
        end else if (w_move) begin
            w_valid_nxt = 1'b1;
            w_ctrl_nxt  = w_skid_ctrl;
            w_data_nxt  = w_skid_data;
        end else if (w_load_in) begin
            w_valid_nxt = 1'b1;
            w_ctrl_nxt  = in_ctrl;
            w_data_nxt  = in_data;
        end else if (w_drain) begin
            // Data is left as is; only control must go bubble-safe
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = CTRL_RST;
        end else begin
            w_valid_nxt = r_valid;
            w_ctrl_nxt  = r_ctrl;
        end
    end

    // Performance counter next-state (never cleared except by reset)
    always_comb begin
        w_stall_nxt = r_stall_cnt;
        w_flush_nxt = r_flush_cnt;
        if (r_valid && !out_ready) begin
            w_stall_nxt = sat_add(r_stall_cnt, 2'd1);
        end else begin
            w_stall_nxt = r_stall_cnt;
        end
        if (flush) begin
            w_flush_nxt = sat_add(r_flush_cnt, occupancy(r_valid, w_skid_valid));
        end else begin
            w_flush_nxt = r_flush_cnt;
        end
    end

    // Stage and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= 1'b0;
            r_ctrl      <= CTRL_RST;
            r_data      <= {DATA_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            r_valid     <= w_valid_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_data      <= w_data_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign out_ctrl   = r_ctrl;
    assign out_data   = r_data;
    assign out_bubble = !r_valid;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pl_stage_reg.sv
module tb_pl_stage_reg;

    localparam int CW = 16;
    localparam int DW = 160;
`ifdef PL_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          hold;
    logic          flush;
    logic          out_ready;

    logic          in_ready, out_valid, out_bubble;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          in_ready4, out_valid4, out_bubble4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [3:0]    stall_cnt4, flush_cnt4;

    beat_t sb[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    exp_stall  = 0;
    int    exp_flush  = 0;

    always #5 CLK = ~CLK;

    pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(16'h0000), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_bubble(out_bubble), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pl_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(16'h0000), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_data(in_data), .hold(hold), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
        .out_data(out_data4), .out_bubble(out_bubble4), .stall_cnt(stall_cnt4),
        .flush_cnt(flush_cnt4)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the DUTs against the scoreboard, then advance the model by one edge.
    task automatic step();
        int   occ;
        logic exp_rdy;
        int   sat4s, sat4f;
        #1;
        occ = sb.size();
        if (SKID) exp_rdy = !hold && !flush && (occ < 2);
        else      exp_rdy = !hold && !flush && ((occ == 0) || out_ready);
        sat4s = (exp_stall > 15) ? 15 : exp_stall;
        sat4f = (exp_flush > 15) ? 15 : exp_flush;
        chk("in_ready",   DW'(in_ready),   DW'(exp_rdy));
        chk("in_ready4",  DW'(in_ready4),  DW'(exp_rdy));
        chk("out_valid",  DW'(out_valid),  DW'(occ != 0));
        chk("out_bubble", DW'(out_bubble), DW'(occ == 0));
        chk("out_valid4", DW'(out_valid4), DW'(occ != 0));
        if (occ != 0) begin
            chk("out_ctrl", DW'(out_ctrl), DW'(sb[0].c));
            chk("out_data", out_data, sb[0].d);
            chk("out_data4", out_data4, sb[0].d);
        end else begin
            chk("out_ctrl_bubble",  DW'(out_ctrl),  DW'(16'h0000));
            chk("out_ctrl4_bubble", DW'(out_ctrl4), DW'(16'h0000));
        end
        chk("stall_cnt",  DW'(stall_cnt),  DW'(exp_stall));
        chk("flush_cnt",  DW'(flush_cnt),  DW'(exp_flush));
        chk("stall_cnt4", DW'(stall_cnt4), DW'(sat4s));
        chk("flush_cnt4", DW'(flush_cnt4), DW'(sat4f));
        if (RST) begin
            sb.delete();
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if ((occ != 0) && !out_ready && (exp_stall < 65535)) exp_stall++;
            if (flush) begin
                exp_flush = exp_flush + occ;
                if (exp_flush > 65535) exp_flush = 65535;
                sb.delete();
            end else begin
                if ((occ != 0) && out_ready) void'(sb.pop_front());
                if (in_valid && exp_rdy) sb.push_back(beat_t'{c: in_ctrl, d: in_data});
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic offer(input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_ctrl = 16'h0000; in_data = {DW{1'b0}};
        hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk("rst_data", out_data, {DW{1'b0}});

        // Stream 8 beats back to back with the downstream always ready
        for (int i = 0; i < 8; i++) begin
            offer(16'h0100 + 16'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Reset for two cycles in the middle of a stalled stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(16'h0200 + 16'(i));
            step();
        end
        RST = 1'b1;
        step();
        step();
        RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("rst_data_mid", out_data, {DW{1'b0}});

        // Latch an all-ones control beat, then flush while another beat is offered
        out_ready = 1'b0;
        offer(16'hFFFF);
        step();
        offer(16'h1234);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_cnt_one", DW'(flush_cnt), DW'(16'd1));

        // Hold for three cycles with the stage full and downstream stalled
        offer(16'h0A0A);
        step();
        in_valid = 1'b0;
        hold = 1'b1;
        offer(16'h0B0B);
        repeat (3) step();
        flush = 1'b1;
        step();
        hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();

        // Beat A fills main, beat B offered while stalled, then release
        offer(16'h00AA);
        step();
        offer(16'h00BB);
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Fill and stall long enough to saturate the 4-bit stall counter
        out_ready = 1'b0;
        offer(16'h0C0C);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        out_ready = 1'b1;
        repeat (2) step();

        // Randomised traffic with occasional hold and flush
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_ctrl   = 16'($urandom());
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = 1'($urandom_range(0, 2) != 0);
            hold      = 1'($urandom_range(0, 7) == 0);
            flush     = 1'($urandom_range(0, 11) == 0);
            step();
        end
        in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
